cm0_irq_conditioner: RTL
========================

CM0_IRQ_CONDITIONER -- requirements
Module: cm0_irq_conditioner

Interface
REQ-001 The block SHALL have parameter NUMIRQ, default 32, number of implemented IRQ lines (1..32).
REQ-002 The block SHALL have parameter SYNC, default 2, synchronizer depth (2 or 3).
REQ-003 The block SHALL have parameter EDGEMASK, default 32'h0, where bit i = 1 makes IRQ line i edge-triggered and 0 makes it level.
REQ-004 The block SHALL have parameter STRETCH, default 4, edge-mode IRQ pulse width in cycles (1..15).
REQ-005 The block SHALL have parameter NMIFILT, default 3, NMI glitch-filter length in cycles (1..15).
REQ-006 The block SHALL have parameter STDIV, default 100, HCLK cycles per STCLKEN pulse (2..2^24).
REQ-007 The block SHALL have parameters TENMS (default 24'd999), reported in STCALIB, and SKEW (default 1'b0).
REQ-008 HCLK  in  1  sole clock; all flops rise-edge.
REQ-009 HRESET  in  1  reset, asynchronous assert, active-high; one clock, asynchronous active-high reset.
REQ-010 IRQSRC  in  32  asynchronous interrupt sources.
REQ-011 NMISRC  in  1  asynchronous NMI source.
REQ-012 EVSRC  in  1  asynchronous event source.
REQ-013 STEN  in  1  SysTick reference enable, synchronous to HCLK.
REQ-014 IRQ  out  32  conditioned interrupts to the core IRQ input.
REQ-015 NMI  out  1  filtered NMI to the core.
REQ-016 RXEV  out  1  single-cycle event pulse to the core.
REQ-017 STCLKEN  out  1  SysTick reference clock enable.
REQ-018 STCALIB  out  26  {1'b0 (NOREF), SKEW, TENMS}, constant.

Function
REQ-019 Each source SHALL pass through a SYNC-flop synchronizer; the synchronized value is s[i].
REQ-020 Level line i (EDGEMASK[i]=0, i<NUMIRQ): IRQ[i] SHALL be a register loaded from s[i], giving SYNC+1 cycles of latency from the first sampling edge.
REQ-021 Edge line i: the block SHALL detect s[i]=1 with a previous value of 0, load a 4-bit counter with STRETCH, and assert IRQ[i] (registered) while the counter is non-zero, decrementing once per cycle.
REQ-022 A new rising edge during the stretch SHALL reload STRETCH and SHALL NOT deassert IRQ[i].
REQ-023 Lines i>=NUMIRQ SHALL drive IRQ[i]=0 and SHALL contain no flops.
REQ-024 The NMI output SHALL change only after the synchronized NMI has differed from the current NMI for NMIFILT consecutive cycles; the filter counter SHALL clear whenever they agree.
REQ-025 RXEV SHALL be a registered one-cycle pulse on each synchronized EVSRC rising edge.
REQ-026 STCLKEN counter: with STEN=1, the counter SHALL count 0..STDIV-1 and wrap to 0; STCLKEN SHALL be registered high for exactly the one cycle after the counter equals STDIV-1.
REQ-027 With STEN=0, the counter SHALL be held at 0 and STCLKEN SHALL be 0; when STEN rises, the first pulse SHALL occur STDIV cycles later.
REQ-028 STCALIB SHALL be purely combinational from parameters.

Reset
REQ-029 While HRESET=1, all synchronizer flops, counters, IRQ, NMI, RXEV and STCLKEN SHALL be 0, independent of HCLK.
REQ-030 Reset asserted mid-stretch, mid-filter or mid-count SHALL drop the outputs immediately; after release, operation SHALL restart from the all-zero state.
REQ-031 A source held high through reset release SHALL be treated as a rising edge after synchronization.

Verification
REQ-032 Level: SYNC=2, IRQSRC[3] 0->1 -> IRQ[3]=1 on the 3rd HCLK edge and follows IRQSRC[3] when it returns to 0.
REQ-033 Edge: EDGEMASK[5]=1, STRETCH=4, 1-cycle pulse on IRQSRC[5] -> IRQ[5] high exactly 4 cycles; a second pulse 2 cycles later -> 6 cycles high in total.
REQ-034 NMI filter: NMIFILT=3, NMISRC 2-cycle glitch -> NMI stays 0; NMISRC held 5 cycles -> NMI=1 three cycles after s rises.
REQ-035 SysTick: STDIV=5, STEN=1 -> STCLKEN pulse every 5th cycle; STEN=0 mid-count -> no pulse; STCALIB = 26'h00003E7.
REQ-036 Reset: HRESET during an active stretch and during RXEV -> all outputs 0 asynchronously; NUMIRQ=8 -> IRQ[31:8] always 0.

Source files
------------

// File: rtl/cm0_irq_conditioner.sv
// Interrupt/event conditioning front-end for a Cortex-M0 style core.
// Synchronizes asynchronous IRQ/NMI/event sources, shapes IRQs as level
// or stretched edge pulses, glitch-filters NMI and generates the SysTick
// reference enable together with a constant calibration word.
`timescale 1ns/1ps

module Cm0IrqSync #(
  parameter int DEPTH = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] sync_q;

  // Shift the asynchronous input through DEPTH flops to settle metastability
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[DEPTH-2:0], d_i};
    end
  end

  assign q_o = sync_q[DEPTH-1];

endmodule

module cm0_irq_conditioner #(
  parameter int          NUMIRQ   = 32,
  parameter int          SYNC     = 2,
  parameter logic [31:0] EDGEMASK = 32'h0,
  parameter int          STRETCH  = 4,
  parameter int          NMIFILT  = 3,
  parameter int          STDIV    = 100,
  parameter logic [23:0] TENMS    = 24'd999,
  parameter logic        SKEW     = 1'b0
) (
  input  logic        HCLK_i,
  input  logic        HRESET_i,
  input  logic [31:0] IRQSRC_i,
  input  logic        NMISRC_i,
  input  logic        EVSRC_i,
  input  logic        STEN_i,
  output logic [31:0] IRQ_o,
  output logic        NMI_o,
  output logic        RXEV_o,
  output logic        STCLKEN_o,
  output logic [25:0] STCALIB_o
);

  localparam logic [3:0]  STRETCH_VAL = 4'(STRETCH);
  localparam logic [3:0]  NMI_LAST    = 4'(NMIFILT - 1);
  localparam logic [23:0] STDIV_LAST  = 24'(STDIV - 1);

  // ---------------- IRQ lines ----------------
  for (genvar i = 0; i < 32; i++) begin : gLine
    if (i < NUMIRQ) begin : gImpl
      logic sIrq;

      Cm0IrqSync #(.DEPTH(SYNC)) uSync (
        .clk_i (HCLK_i),
        .rst_i (HRESET_i),
        .d_i   (IRQSRC_i[i]),
        .q_o   (sIrq)
      );

      if (EDGEMASK[i]) begin : gEdge
        logic       prev_q;
        logic [3:0] stretchCnt_q;
        logic [3:0] stretchCnt_d;
        logic       irq_q;

        // A rising edge (re)loads the stretch counter, otherwise it runs down to zero
        always_comb begin
          stretchCnt_d = stretchCnt_q;
          if (sIrq && !prev_q) begin
            stretchCnt_d = STRETCH_VAL;
          end else if (stretchCnt_q != 4'd0) begin
            stretchCnt_d = stretchCnt_q - 4'd1;
          end
        end

        // Register edge history, the counter and the IRQ seen while it is non-zero
        always_ff @(posedge HCLK_i or posedge HRESET_i) begin
          if (HRESET_i) begin
            prev_q       <= 1'b0;
            stretchCnt_q <= 4'd0;
            irq_q        <= 1'b0;
          end else begin
            prev_q       <= sIrq;
            stretchCnt_q <= stretchCnt_d;
            irq_q        <= (stretchCnt_d != 4'd0);
          end
        end

        assign IRQ_o[i] = irq_q;
      end else begin : gLevel
        logic irq_q;

        // Level lines simply register the synchronized source
        always_ff @(posedge HCLK_i or posedge HRESET_i) begin
          if (HRESET_i) begin
            irq_q <= 1'b0;
          end else begin
            irq_q <= sIrq;
          end
        end

        assign IRQ_o[i] = irq_q;
      end
    end else begin : gAbsent
      logic unusedSrc;
      assign unusedSrc = IRQSRC_i[i];
      assign IRQ_o[i]  = 1'b0;
    end
  end

  // ---------------- NMI glitch filter ----------------
  logic       sNmi;
  logic       nmi_q;
  logic       nmi_d;
  logic [3:0] nmiFilt_q;
  logic [3:0] nmiFilt_d;

  Cm0IrqSync #(.DEPTH(SYNC)) uNmiSync (
    .clk_i (HCLK_i),
    .rst_i (HRESET_i),
    .d_i   (NMISRC_i),
    .q_o   (sNmi)
  );

  // Count consecutive disagreeing cycles; flip the output once the run is long enough
  always_comb begin
    nmi_d     = nmi_q;
    nmiFilt_d = 4'd0;
    if (sNmi != nmi_q) begin
      if (nmiFilt_q == NMI_LAST) begin
        nmi_d = sNmi;
      end else begin
        nmiFilt_d = nmiFilt_q + 4'd1;
      end
    end
  end

  // NMI filter state
  always_ff @(posedge HCLK_i or posedge HRESET_i) begin
    if (HRESET_i) begin
      nmi_q     <= 1'b0;
      nmiFilt_q <= 4'd0;
    end else begin
      nmi_q     <= nmi_d;
      nmiFilt_q <= nmiFilt_d;
    end
  end

  assign NMI_o = nmi_q;

  // ---------------- Event pulse ----------------
  logic sEv;
  logic evPrev_q;
  logic rxev_q;

  Cm0IrqSync #(.DEPTH(SYNC)) uEvSync (
    .clk_i (HCLK_i),
    .rst_i (HRESET_i),
    .d_i   (EVSRC_i),
    .q_o   (sEv)
  );

  // One registered pulse per synchronized rising edge of the event source
  always_ff @(posedge HCLK_i or posedge HRESET_i) begin
    if (HRESET_i) begin
      evPrev_q <= 1'b0;
      rxev_q   <= 1'b0;
    end else begin
      evPrev_q <= sEv;
      rxev_q   <= sEv && !evPrev_q;
    end
  end

  assign RXEV_o = rxev_q;

  // ---------------- SysTick reference enable ----------------
  logic [23:0] stCnt_q;
  logic [23:0] stCnt_d;
  logic        stclken_q;
  logic        stclken_d;

  // Divide HCLK by STDIV while enabled; disabling parks the counter at zero
  always_comb begin
    stCnt_d   = 24'd0;
    stclken_d = 1'b0;
    if (STEN_i) begin
      if (stCnt_q == STDIV_LAST) begin
        stclken_d = 1'b1;
      end else begin
        stCnt_d = stCnt_q + 24'd1;
      end
    end
  end

  // SysTick divider state
  always_ff @(posedge HCLK_i or posedge HRESET_i) begin
    if (HRESET_i) begin
      stCnt_q   <= 24'd0;
      stclken_q <= 1'b0;
    end else begin
      stCnt_q   <= stCnt_d;
      stclken_q <= stclken_d;
    end
  end

  assign STCLKEN_o = stclken_q;
  assign STCALIB_o = {1'b0, SKEW, TENMS};

endmodule
